imem_loader: RTL and testbench

Program loader for the MIPS32 pipeline's instruction memory: the writer that fills the word array `ifetch` reads. It accepts a byte stream over a valid/ready handshake, packs bytes big-endian into 32-bit instructions, and writes them to consecutive word addresses starting at 0. It holds the core in code mode (`core_run`=0) until a complete, valid program is loaded, then releases it to execute mode.

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/imem_word_packer.sv | 34 +++
 rtl/imem_loader.sv | 112 +++++++++++
 tb/tb_imem_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared states and sizing for the instruction-memory loader
package imem_loader_pkg;

    localparam int IMEM_DEPTH = 1024;
    localparam int LEN_W      = 16;
    localparam int LANES      = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_LAST,
        S_DONE,
        S_ERROR,
        S_CSUM
    } state_t;

    function automatic logic accepts_bytes(input state_t s);
        return s inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM};
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: collects stream bytes big-endian into 32-bit instruction words
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]              lane;
    logic [8*(LANES-1)-1:0]  sr;

    // the 4th byte completes the word combinationally so the top can register it at once
    assign word_valid = en && lane == 2'(LANES - 1);
    assign word       = {sr, data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane <= '0;
            sr   <= '0;
        end else if (clr) begin
            lane <= '0;
            sr   <= '0;
        end else if (en) begin
            lane <= lane + 2'd1;
            sr   <= {sr[8*(LANES-2)-1:0], data};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a length-prefixed byte stream, then releases the core
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          core_run
);

    state_t           state, state_nx, after_data;
    logic             xfer, launch, word_valid, last_word;
    logic [7:0]       len_hi;
    logic [LEN_W-1:0] len, len_in, word_cnt;
    logic [31:0]      word;

    assign in_ready  = accepts_bytes(state);
    assign busy      = state inside {S_LEN_HI, S_LEN_LO, S_DATA, S_LAST, S_CSUM};
    assign done      = state == S_DONE;
    assign err       = state == S_ERROR;
    assign core_run  = done;
    assign xfer      = in_valid && in_ready;
    assign launch    = start && state inside {S_IDLE, S_DONE, S_ERROR};
    assign len_in    = {len_hi, in_data};
    assign last_word = word_valid && (word_cnt + LEN_W'(1)) == len;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    assign after_data = S_CSUM;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            csum <= '0;
        else
            csum <= launch ? 8'h00 : (xfer && state == S_DATA) ? csum ^ in_data : csum;
    end
`else
    assign after_data = S_LAST;
`endif

    imem_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (launch),
        .en         (xfer && state == S_DATA),
        .data       (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: state_nx = launch ? S_LEN_HI : state;
            S_LEN_HI: state_nx = xfer ? S_LEN_LO : state;
            S_LEN_LO: state_nx = !xfer ? state
                               : 32'(len_in) > DEPTH ? S_ERROR
                               : len_in == '0 ? after_data : S_DATA;
            S_DATA:   state_nx = last_word ? after_data : state;
            S_LAST:   state_nx = S_DONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM:   state_nx = !xfer ? state : in_data == csum ? S_LAST : S_ERROR;
`endif
            default:  state_nx = S_IDLE;
        endcase
    end

    // word_cnt doubles as the write address; it stops at N <= DEPTH so it never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_hi     <= '0;
            len        <= '0;
            word_cnt   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= word_valid;
            if (launch)
                word_cnt <= '0;
            if (xfer && state == S_LEN_HI)
                len_hi <= in_data;
            if (xfer && state == S_LEN_LO)
                len <= len_in;
            if (word_valid) begin
                imem_addr  <= word_cnt[AW-1:0];
                imem_wdata <= word;
                word_cnt   <= word_cnt + LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader; writes are predicted as bytes are driven
module tb_imem_loader;

    localparam int DEPTH = 1024;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready, imem_we, busy, done, err, core_run;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    int              n_checks = 0;
    int              n_errors = 0;
    int              exp_addr = 0;
    logic [AW+31:0]  sb[$];
    logic [AW+31:0]  sb_item;
    logic [31:0]     wv[4];

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .core_run   (core_run)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_we", 64'(imem_addr), 64'hFFFF);
            end else begin
                sb_item = sb.pop_front();
                check("we_addr", 64'(imem_addr), 64'(sb_item[AW+31:32]));
                check("we_data", 64'(imem_wdata), 64'(sb_item[31:0]));
            end
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        int n = 0;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            if (++n > 50) begin
                check("ready_timeout", 64'(in_ready), 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_addr = 0;
    endtask

    task automatic load(input int n, input logic gaps, input logic pulse, input logic [7:0] cs_flip);
        logic [7:0] cs = 8'h00;
        logic [7:0] b;
        send(8'(n >> 8), 0);
        send(8'(n), 0);
        for (int i = 0; i < n; i++) begin
            for (int j = 3; j >= 0; j--) begin
                b = wv[i][8*j +: 8];
                cs ^= b;
                if (j == 0) begin
                    sb.push_back({AW'(exp_addr), wv[i]});
                    exp_addr++;
                end
                start = pulse && i == 0 && j == 1;
                send(b, gaps ? int'($urandom_range(0, 3)) : 0);
                start = 1'b0;
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(cs ^ cs_flip, 0);
`else
        cs = cs ^ cs_flip;
`endif
    endtask

    task automatic expect_done(input string tag);
        @(negedge clk);
        check({tag, "_early"}, 64'({done, err, core_run, busy}), 64'b0001);
        @(negedge clk);
        check({tag, "_final"}, 64'({done, err, core_run, busy, in_ready}), 64'b10100);
    endtask

    initial begin
        #1;
        check("reset_outs", {in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, core_run}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic two-word load
        do_start();
        check("busy_after_start", 64'(busy), 64'd1);
        wv[0] = 32'h12345678; wv[1] = 32'h9ABCDEF0;
        load(2, 1'b0, 1'b0, 8'h00);
        expect_done("basic");

        // bytes offered in DONE are not consumed
        in_valid = 1'b1; in_data = 8'hAA;
        repeat (3) @(negedge clk);
        check("done_hold", 64'({done, core_run, in_ready}), 64'b110);
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        // restart from DONE, with gaps and an ignored mid-load start
        do_start();
        check("restart_core_run", 64'({core_run, done, busy}), 64'b001);
        wv[0] = 32'hDEADBEEF; wv[1] = 32'h0BADF00D; wv[2] = 32'h13579BDF;
        load(3, 1'b1, 1'b1, 8'h00);
        expect_done("gapped");

        // oversize length
        do_start();
        send(8'h04, 0);
        send(8'h01, 0);
        @(negedge clk);
        check("oversize_err", 64'({err, in_ready, busy, core_run, done}), 64'b10000);
        in_valid = 1'b1; in_data = 8'h55;
        repeat (2) @(negedge clk);
        check("err_hold", 64'({err, in_ready}), 64'b10);
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        // zero-length program
        do_start();
        load(0, 1'b0, 1'b0, 8'h00);
        expect_done("zero_len");

        // asynchronous reset mid-load
        do_start();
        send(8'h00, 0);
        send(8'h03, 0);
        wv[0] = 32'hA1B2C3D4;
        sb.push_back({AW'(0), wv[0]});
        for (int j = 3; j >= 0; j--) send(wv[0][8*j +: 8], 0);
        send(8'h77, 0);
        send(8'h88, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midload_reset", {in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, core_run}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_start();
        wv[0] = 32'hCAFEF00D;
        load(1, 1'b0, 1'b0, 8'h00);
        expect_done("after_reset");

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_start();
        wv[0] = 32'h01020304;
        load(1, 1'b0, 1'b0, 8'h00);
        expect_done("csum_ok");
        do_start();
        load(1, 1'b0, 1'b0, 8'h01);
        @(negedge clk);
        check("csum_bad", 64'({err, core_run, done}), 64'b100);
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule
